// File: rtl/addsub_pipe.sv
// addsub_pipe: carry-pipelined adder/subtractor, one WIDTH/STAGES-bit slice per stage, valid/ready handshake.
// Define ADDSUB_SAT_EN to saturate Y to signed max/min on overflow instead of wrapping.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIN,
  input  logic             Sub,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Y,
  output logic             CarryOUT,
  output logic             Overflow,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int SLICE  = WIDTH / STAGES;
  localparam int PART_W = SLICE + 1;

  // Stage gi consumes index gi and produces index gi+1; index STAGES is the output register set.
  // Operands shift right one slice per stage so the active slice always sits at the bottom,
  // while finished result slices enter from the top and land aligned after the last stage.
  logic [WIDTH-1:0] srcA     [STAGES];
  logic [WIDTH-1:0] srcB     [STAGES];
  logic [WIDTH-1:0] srcSum   [STAGES+1];
  logic             srcCarry [STAGES+1];
  logic             srcValid [STAGES+1];
  logic             advance;
  logic             ovReg;

  assign advance = !srcValid[STAGES] || OutReady;
  assign InReady = advance;

  // Subtract is A + ~B + ~CarryIN, so CarryIN acts as a borrow-in.
  assign srcA[0]     = A;
  assign srcB[0]     = Sub ? ~B : B;
  assign srcSum[0]   = '0;
  assign srcCarry[0] = Sub ? ~CarryIN : CarryIN;
  assign srcValid[0] = InValid;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gStage
      logic [SLICE:0]   part;
      logic [WIDTH-1:0] sumNext;
      logic [WIDTH-1:0] sumIn;
      logic [WIDTH-1:0] sumReg;
      logic             carryReg;
      logic             validReg;

      assign part = {1'b0, srcA[gi][SLICE-1:0]}
                  + {1'b0, srcB[gi][SLICE-1:0]}
                  + PART_W'(srcCarry[gi]);

      assign sumNext = (srcSum[gi] >> SLICE)
                     | (WIDTH'(part[SLICE-1:0]) << (WIDTH - SLICE));

      if (gi == STAGES - 1) begin : gLast
        logic             aSign;
        logic             bSign;
        logic             ovNext;
        logic [WIDTH-1:0] yNext;

        // The top slice's operand MSBs are the full-width sign bits.
        assign aSign  = srcA[gi][SLICE-1];
        assign bSign  = srcB[gi][SLICE-1];
        assign ovNext = (aSign == bSign) && (part[SLICE-1] != aSign);

`ifdef ADDSUB_SAT_EN
        // Operands share a sign on overflow, so that sign gives the true result's sign.
        assign yNext = !ovNext ? sumNext
                     : aSign   ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
`else
        assign yNext = sumNext;
`endif

        assign sumIn = yNext;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovReg <= 1'b0;
          end else if (advance) begin
            ovReg <= ovNext;
          end
        end
      end else begin : gMid
        logic [WIDTH-1:0] aReg;
        logic [WIDTH-1:0] bReg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            aReg <= '0;
            bReg <= '0;
          end else if (advance) begin
            aReg <= srcA[gi] >> SLICE;
            bReg <= srcB[gi] >> SLICE;
          end
        end

        assign srcA[gi+1] = aReg;
        assign srcB[gi+1] = bReg;
        assign sumIn      = sumNext;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          validReg <= 1'b0;
          carryReg <= 1'b0;
          sumReg   <= '0;
        end else if (advance) begin
          validReg <= srcValid[gi];
          carryReg <= part[SLICE];
          sumReg   <= sumIn;
        end
      end

      assign srcSum[gi+1]   = sumReg;
      assign srcCarry[gi+1] = carryReg;
      assign srcValid[gi+1] = validReg;
    end
  endgenerate

  assign Y        = srcSum[STAGES];
  assign CarryOUT = srcCarry[STAGES];
  assign Overflow = ovReg;
  assign OutValid = srcValid[STAGES];

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; each stage adds one WIDTH/STAGES-bit slice.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 CarryIN  input  1  carry-in (add) / borrow-in (subtract).
REQ-008 Sub  input  1  mode: 0 = add, 1 = subtract.
REQ-009 InValid  input  1  A/B/CarryIN/Sub valid this cycle.
REQ-010 InReady  output  1  block accepts input this cycle.
REQ-011 Y  output  WIDTH  result.
REQ-012 CarryOUT  output  1  unsigned carry-out of MSB (subtract: 1 = no borrow).
REQ-013 Overflow  output  1  signed two's-complement overflow.
REQ-014 OutValid  output  1  Y/CarryOUT/Overflow valid.
REQ-015 OutReady  input  1  downstream accepts result.

Function
REQ-016 Add: {CarryOUT,Y} SHALL equal A + B + CarryIN, modulo 2^(WIDTH+1).
REQ-017 Subtract: SHALL compute A + ~B + ~CarryIN; Y = A - B - CarryIN mod 2^WIDTH; CarryOUT is raw MSB carry.
REQ-018 Overflow SHALL be 1 iff the MSB operands (A, B or ~B) share a sign that differs from Y's sign.
REQ-019 Stage k (0..STAGES-1) SHALL add slice k of operands using stage k-1's registered carry; higher slices and lower result slices SHALL travel in skew registers alongside.
REQ-020 Advance = !OutValid || OutReady; InReady SHALL equal Advance (combinational, no dependency on InValid).
REQ-021 On Advance, all stages SHALL shift one step together; a stage with no valid token SHALL carry a bubble (valid bit 0).
REQ-022 When Advance is 0, every stage register and all outputs SHALL hold.
REQ-023 Latency: input accepted at edge n SHALL appear with OutValid=1 after edge n+STAGES-1+1 (i.e. STAGES cycles) when no stall occurs.
REQ-024 Throughput: one result per cycle when InValid and OutReady are held at 1.
REQ-025 A transfer occurs on an edge where OutValid && OutReady; results SHALL emerge in acceptance order, none dropped or duplicated.
REQ-026 Simultaneous accept and output on one edge SHALL be supported with no bubble inserted.
REQ-027 Y, CarryOUT, Overflow SHALL be registered outputs, stable while OutValid=1 and OutReady=0.
REQ-028 STAGES=1 SHALL degenerate to a single-register full-width adder with latency 1.

Reset
REQ-029 rst=1 SHALL immediately clear all stage valid bits, OutValid, Y, CarryOUT, Overflow to 0, independent of clk.
REQ-030 Tokens in flight at reset assertion SHALL be discarded; none SHALL appear after deassertion.
REQ-031 InReady SHALL be 1 during and on the first edge after reset (OutValid=0).

Configuration
REQ-032 Macro ADDSUB_SAT_EN: when defined, on Overflow=1 Y SHALL saturate to signed max (0x7FFF for WIDTH=16) if true result positive, signed min (0x8000) if negative; Overflow still reports 1, CarryOUT unchanged.
REQ-033 Without ADDSUB_SAT_EN, Y SHALL be the wrapped result and no saturation logic SHALL be present.

Verification (WIDTH=16, STAGES=4)
REQ-034 Add A=0x00FF, B=0x0001, CarryIN=0, OutReady=1 -> 4 cycles later Y=0x0100, CarryOUT=0, Overflow=0.
REQ-035 Add A=0xFFFF, B=0x0001, CarryIN=1 -> Y=0x0001, CarryOUT=1, Overflow=0; Add A=0x7FFF, B=0x0001 -> Y=0x8000 (0x7FFF with ADDSUB_SAT_EN), Overflow=1.
REQ-036 Sub A=0x0005, B=0x0007, CarryIN=0 -> Y=0xFFFE, CarryOUT=0; Sub A=0x8000, B=0x0001 -> Overflow=1, Y=0x7FFF (0x8000 with ADDSUB_SAT_EN).
REQ-037 Stream 8 back-to-back tokens, OutReady low for 3 cycles mid-stream -> InReady low same cycles, outputs held, all 8 results in order, none lost.
REQ-038 Assert rst asynchronously with 3 tokens in flight -> OutValid/Y drop to 0 before next edge; no stale result after release.
